// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_seq_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_MUL = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// The first partial product is folded into the start cycle, so done pulses
// WIDTH cycles after start and product is final while done is high.
module mul_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               busy;

  assign product = acc;

  // Load on start (bit 0 applied), then one shift-add step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier <= {1'b0, b[WIDTH-1:1]};
        count  <= CW'(WIDTH - 1);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - 1'b1;
        if (count == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU. One instruction in flight; single-cycle ops
// finish one cycle after accept, MUL after WIDTH+1 cycles.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; in_ready is high only in IDLE, out_valid only in DONE, and the
// result outputs are held stable for as long as out_valid waits on out_ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW+2*WIDTH-1:0] in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       extended_out,
  output logic                   carry,
  output logic                   overflow,
  output logic                   illegal
);

  state_t state;

  logic [OPW-1:0]     op;
  logic [WIDTH-1:0]   oper1;
  logic [WIDTH-1:0]   oper2;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               add_ovf;
  logic               sub_ovf;

  logic [WIDTH-1:0]   res_out;
  logic               res_carry;
  logic               res_ovf;
  logic               res_illegal;

  assign op    = in_instr[OPW+2*WIDTH-1 -: OPW];
  assign oper1 = in_instr[2*WIDTH-1:WIDTH];
  assign oper2 = in_instr[WIDTH-1:0];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  // Arithmetic on WIDTH+1 bits; the top bit is carry for ADD, borrow for SUB.
  assign sum     = {1'b0, oper1} + {1'b0, oper2};
  assign diff    = {1'b0, oper1} - {1'b0, oper2};
  assign add_ovf = (oper1[WIDTH-1] == oper2[WIDTH-1]) && (sum[WIDTH-1] != oper1[WIDTH-1]);
  assign sub_ovf = (oper1[WIDTH-1] != oper2[WIDTH-1]) && (diff[WIDTH-1] != oper1[WIDTH-1]);

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (oper1),
    .b       (oper2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result; a signed overflow zeroes out but keeps carry.
  always_comb begin
    res_out     = '0;
    res_carry   = 1'b0;
    res_ovf     = 1'b0;
    res_illegal = 1'b0;
    case (op)
      OP_ADD: begin
        res_carry = sum[WIDTH];
        res_ovf   = add_ovf;
        res_out   = add_ovf ? '0 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        res_carry = diff[WIDTH];
        res_ovf   = sub_ovf;
        res_out   = sub_ovf ? '0 : diff[WIDTH-1:0];
      end
      OP_AND:  res_out = oper1 & oper2;
      OP_OR:   res_out = oper1 | oper2;
      OP_XOR:  res_out = oper1 ^ oper2;
      OP_MUL:  res_out = '0;
      default: res_illegal = 1'b1;
    endcase
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      out          <= '0;
      extended_out <= '0;
      carry        <= 1'b0;
      overflow     <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state <= ST_MUL_BUSY;
            end else begin
              state        <= ST_DONE;
              out          <= res_out;
              extended_out <= '0;
              carry        <= res_carry;
              overflow     <= res_ovf;
              illegal      <= res_illegal;
            end
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            state        <= ST_DONE;
            out          <= mul_product[WIDTH-1:0];
            extended_out <= mul_product[2*WIDTH-1:WIDTH];
            carry        <= 1'b0;
            overflow     <= 1'b0;
            illegal      <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_alu_seq;

  localparam int RW = 67;  // {ext[31:0], out[31:0], carry, overflow, illegal}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel16     = 1'b0;
  logic [2:0]  op_r      = '0;
  logic [15:0] a_r       = '0;
  logic [15:0] b_r       = '0;

  logic        in_ready8, out_valid8, carry8, ovf8, ill8;
  logic [7:0]  out8, ext8;
  logic        in_ready16, out_valid16, carry16, ovf16, ill16;
  logic [15:0] out16, ext16;
  logic [18:0] instr8;
  logic [34:0] instr16;
  logic        iv8, iv16, or8, or16;

  assign instr8  = {op_r, a_r[7:0], b_r[7:0]};
  assign instr16 = {op_r, a_r, b_r};
  assign iv8     = in_valid & ~sel16;
  assign iv16    = in_valid & sel16;
  assign or8     = out_ready & ~sel16;
  assign or16    = out_ready & sel16;

  alu_seq #(.WIDTH(8), .OPW(3)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(in_ready8),
    .in_instr(instr8), .out_valid(out_valid8), .out_ready(or8),
    .out(out8), .extended_out(ext8), .carry(carry8), .overflow(ovf8),
    .illegal(ill8)
  );

  alu_seq #(.WIDTH(16), .OPW(3)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(in_ready16),
    .in_instr(instr16), .out_valid(out_valid16), .out_ready(or16),
    .out(out16), .extended_out(ext16), .carry(carry16), .overflow(ovf16),
    .illegal(ill16)
  );

  logic          rdy, vld;
  logic [RW-1:0] obs;
  assign rdy = sel16 ? in_ready16 : in_ready8;
  assign vld = sel16 ? out_valid16 : out_valid8;
  assign obs = sel16 ? {16'b0, ext16, 16'b0, out16, carry16, ovf16, ill16}
                     : {24'b0, ext8, 24'b0, out8, carry8, ovf8, ill8};

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_exp = '0;

  task automatic check(input string tag, input logic [RW-1:0] o, input logic [RW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Reference model written from the opcode definitions.
  function automatic logic [RW-1:0] model(input int w, input logic [2:0] op,
                                          input longint unsigned a, input longint unsigned b);
    longint unsigned one  = 1;
    longint unsigned mask = (one << w) - 1;
    longint unsigned half = one << (w - 1);
    longint unsigned r = 0, e = 0, p;
    longint sa, sb, ss;
    logic c = 1'b0, v = 1'b0, il = 1'b0;
    sa = longint'(a);
    sb = longint'(b);
    if (a >= half) sa -= longint'(one << w);
    if (b >= half) sb -= longint'(one << w);
    case (op)
      3'b000: begin
        r  = a + b;
        c  = (r > mask);
        ss = sa + sb;
        v  = (ss > longint'(half) - 1) || (ss < -longint'(half));
        r  = v ? 0 : (r & mask);
      end
      3'b100: begin
        c  = (a < b);
        r  = (a - b) & mask;
        ss = sa - sb;
        v  = (ss > longint'(half) - 1) || (ss < -longint'(half));
        if (v) r = 0;
      end
      3'b001: r = a & b;
      3'b010: r = a ^ b;
      3'b101: r = a | b;
      3'b011: begin
        p = a * b;
        r = p & mask;
        e = p >> w;
      end
      default: il = 1'b1;
    endcase
    return {e[31:0], r[31:0], c, v, il};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one instruction at a negedge and returns at the negedge after accept.
  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit push);
    int n = 0;
    int w;
    w = sel16 ? 16 : 8;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", RW'(rdy), RW'(1));
    op_r     = op;
    a_r      = a;
    b_r      = b;
    in_valid = 1'b1;
    if (push) exp_q.push_back(model(w, op, longint'(a), longint'(b)));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_r     = 3'($urandom_range(0, 7));
    a_r      = 16'($urandom_range(0, 65535));
    b_r      = 16'($urandom_range(0, 65535));
  endtask

  // Waits for out_valid, checks latency and in_ready while busy, compares result.
  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 1;
    while (!vld && lat < 100) begin
      check({tag, "_busy_in_ready"}, RW'(rdy), RW'(0));
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, RW'(lat), RW'(exp_lat));
    check({tag, "_done_in_ready"}, RW'(rdy), RW'(0));
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check({tag, "_result"}, obs, last_exp);
    end else begin
      check({tag, "_queue_empty"}, RW'(1), RW'(0));
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, RW'(vld), RW'(0));
    check({tag, "_rel_ready"}, RW'(rdy), RW'(1));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int exp_lat);
    drive(op, a, b, 1'b1);
    wait_result(tag, exp_lat);
    release_result(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] ops[5];
    bit         seen;
    ops[0] = 3'b000; ops[1] = 3'b100; ops[2] = 3'b001; ops[3] = 3'b101; ops[4] = 3'b010;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel16 = (s == 1);
      check("reset_outputs", obs, '0);
      check("reset_in_ready", RW'(rdy), RW'(1));
      check("reset_out_valid", RW'(vld), RW'(0));
    end
    sel16 = 1'b0;

    run_op("add_ff_01", 3'b000, 16'h00FF, 16'h0001, 1);
    run_op("add_ovf", 3'b000, 16'h0070, 16'h0020, 1);
    run_op("sub_borrow", 3'b100, 16'h0005, 16'h0007, 1);
    run_op("mul_ff_ff", 3'b011, 16'h00FF, 16'h00FF, 9);
    run_op("mul_zero", 3'b011, 16'h0000, 16'h00AB, 9);
    run_op("illegal_111", 3'b111, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1);
    run_op("illegal_110", 3'b110, 16'h0012, 16'h0034, 1);

    for (int i = 0; i < 6; i++) begin
      run_op("rand8", ops[$urandom_range(0, 4)], 16'($urandom_range(0, 255)),
             16'($urandom_range(0, 255)), 1);
    end
    run_op("mul_rand8", 3'b011, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 9);

    // Backpressure: result held while a competing instruction is offered.
    drive(3'b010, 16'h00F0, 16'h003C, 1'b1);
    wait_result("bp_xor", 1);
    op_r     = 3'b000;
    a_r      = 16'h0011;
    b_r      = 16'h0022;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", RW'(vld), RW'(1));
      check("bp_hold_result", obs, last_exp);
      check("bp_hold_in_ready", RW'(rdy), RW'(0));
    end
    in_valid = 1'b0;
    release_result("bp_xor");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (vld) seen = 1'b1;
    end
    check("bp_no_stray_accept", RW'(seen), RW'(0));

    // Reset on the 4th MUL_BUSY cycle discards the multiply.
    drive(3'b011, 16'h00AB, 16'h00CD, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_outputs", obs, '0);
    check("rst_mid_in_ready", RW'(rdy), RW'(1));
    check("rst_mid_valid", RW'(vld), RW'(0));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (vld) seen = 1'b1;
    end
    check("rst_mid_no_result", RW'(seen), RW'(0));
    run_op("add_after_rst", 3'b000, 16'h0003, 16'h0004, 1);

    // Wide instance.
    sel16 = 1'b1;
    @(negedge clk);
    run_op("mul16_ffff", 3'b011, 16'hFFFF, 16'hFFFF, 17);
    run_op("add16_ffff_1", 3'b000, 16'hFFFF, 16'h0001, 1);
    run_op("add16_ovf", 3'b000, 16'h7000, 16'h2000, 1);
    run_op("sub16", 3'b100, 16'h0005, 16'h0007, 1);
    run_op("mul16_rand", 3'b011, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 17);
    run_op("ill16", 3'b111, 16'h1234, 16'h5678, 1);

    check("queue_drained", RW'(exp_q.size()), RW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
